// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;
  localparam int         CNT_W      = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic       {GNT_I, GNT_D}       gnt_e;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants made while a fetch waits; forces fetch at the limit.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_GRANTS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arb_i,
  input  logic gnt_d_i,
  input  logic i_req_i,
  output logic force_fetch_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (arb_i) begin
      if (gnt_d_i && i_req_i) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      else                    cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign force_fetch_o = i_req_i && (cnt_q == CNT_W'(MAX_DATA_GRANTS));
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store with wait states and alignment checks.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_STATES     = 1,
  parameter int MAX_DATA_GRANTS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  state_e           state_q, state_d;
  gnt_e             gnt_q, gnt_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0]      i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic             we_q, we_d, err_q, err_d;
  logic             arb, force_fetch;
  logic [31:0]      win_addr;

  assign arb      = (state_q == IDLE) && (i_req || d_req);
  assign win      = (d_req && !force_fetch) ? GNT_D : GNT_I;
  assign win_addr = (win == GNT_D) ? d_addr : i_addr;

  mem_arb_starve_ctr #(.MAX_DATA_GRANTS(MAX_DATA_GRANTS)) u_starve (
    .clk          (clk),
    .reset_n      (reset_n),
    .arb_i        (arb),
    .gnt_d_i      (win == GNT_D),
    .i_req_i      (i_req),
    .force_fetch_o(force_fetch)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    err_d     = err_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_err     = 1'b0;
    d_err     = 1'b0;
    unique case (state_q)
      IDLE: if (arb) begin
        gnt_d   = win;
        addr_d  = win_addr;
        we_d    = (win == GNT_D) && d_we;
        wdata_d = (win == GNT_D) ? d_wdata : '0;
        // Unaligned accesses skip the memory entirely and complete with zero data.
        if ((win_addr[1:0] & ALIGN_MASK) != 2'b00) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (win == GNT_D) d_rdata_d = '0;
          else              i_rdata_d = '0;
        end else begin
          err_d   = 1'b0;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we  = we_q;
          state_d = DONE;
          if (gnt_q == GNT_D) d_rdata_d = mem_rdata;
          else                i_rdata_d = mem_rdata;
        end
      end
      DONE: begin
        i_ack   = (gnt_q == GNT_I);
        d_ack   = (gnt_q == GNT_D);
        i_err   = (gnt_q == GNT_I) && err_q;
        d_err   = (gnt_q == GNT_D) && err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_I;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench: transaction-level model checked every cycle plus directed scenarios on two configurations.
module tb_mem_arbiter;
  localparam int W = 1;
  localparam int M = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Main DUT (WAIT_STATES=1, MAX_DATA_GRANTS=4)
  logic        rst_n, i_req, d_req, d_we, i_ack, i_err, d_ack, d_err, mem_we, busy;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [64] = '{2: 32'h2005_0005, default: 32'h0};

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

  mem_arbiter #(.WAIT_STATES(W), .MAX_DATA_GRANTS(M)) dut (
    .clk(clk), .reset_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // Second DUT (WAIT_STATES=3) for the reset-abort scenario
  logic        r_rst_n, r_i_req, r_d_req, r_d_we, r_i_ack, r_i_err, r_d_ack, r_d_err, r_mem_we, r_busy;
  logic [31:0] r_i_addr, r_d_addr, r_d_wdata, r_i_rdata, r_d_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata;
  logic [31:0] r_mem [64] = '{2: 32'h2005_0005, default: 32'h0};
  int          r_we_edges = 0;

  assign r_mem_rdata = r_mem[r_mem_addr[7:2]];
  always @(posedge clk) if (r_mem_we) r_mem[r_mem_addr[7:2]] <= r_mem_wdata;
  always @(posedge clk) if (r_mem_we) r_we_edges <= r_we_edges + 1;

  mem_arbiter #(.WAIT_STATES(3), .MAX_DATA_GRANTS(4)) dut3 (
    .clk(clk), .reset_n(r_rst_n),
    .i_req(r_i_req), .i_addr(r_i_addr), .i_rdata(r_i_rdata), .i_ack(r_i_ack), .i_err(r_i_err),
    .d_req(r_d_req), .d_we(r_d_we), .d_addr(r_d_addr), .d_wdata(r_d_wdata),
    .d_rdata(r_d_rdata), .d_ack(r_d_ack), .d_err(r_d_err),
    .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_we(r_mem_we), .mem_rdata(r_mem_rdata),
    .busy(r_busy)
  );

  // Transaction model: m_t indexes cycles after the grant edge (1 = first cycle).
  bit          m_act, m_wd, m_err, m_we;
  int          m_t, m_ack_at, m_starve;
  logic [31:0] m_addr, m_wdata, m_ird, m_drd;
  logic [31:0] mref [64] = '{2: 32'h2005_0005, default: 32'h0};

  task automatic model_step();
    if (!rst_n) begin
      m_act = 0; m_starve = 0; m_ird = '0; m_drd = '0;
      return;
    end
    if (m_act) begin
      if (m_t == m_ack_at) m_act = 0;
      else begin
        if (!m_err && m_t == W + 1) begin
          if (m_wd) m_drd = mref[m_addr[7:2]];
          else      m_ird = mref[m_addr[7:2]];
          if (m_we) mref[m_addr[7:2]] = m_wdata;
        end
        m_t++;
      end
    end else if (i_req || d_req) begin
      m_wd = d_req && !(i_req && m_starve == M);
      if (m_wd && i_req) m_starve = (m_starve == 15) ? 15 : m_starve + 1;
      else               m_starve = 0;
      m_addr   = m_wd ? d_addr : i_addr;
      m_we     = m_wd && d_we;
      m_wdata  = m_wd ? d_wdata : 32'h0;
      m_err    = (m_addr[1:0] != 2'b00);
      m_ack_at = m_err ? 1 : W + 2;
      m_t      = 1;
      m_act    = 1;
      if (m_err) begin
        if (m_wd) m_drd = '0;
        else      m_ird = '0;
      end
    end
  endtask

  task automatic compare_step();
    bit acc, ack;
    acc = m_act && !m_err && (m_t <= W + 1);
    ack = m_act && (m_t == m_ack_at);
    chk("busy",      busy,      m_act);
    chk("mem_addr",  mem_addr,  acc ? m_addr : 32'h0);
    chk("mem_wdata", mem_wdata, acc ? m_wdata : 32'h0);
    chk("mem_we",    mem_we,    acc && (m_t == W + 1) && m_we);
    chk("i_ack",     i_ack,     ack && !m_wd);
    chk("d_ack",     d_ack,     ack && m_wd);
    chk("i_err",     i_err,     ack && !m_wd && m_err);
    chk("d_err",     d_err,     ack && m_wd && m_err);
    chk("i_rdata",   i_rdata,   m_ird);
    chk("d_rdata",   d_rdata,   m_drd);
    chk("ack_excl",  i_ack & d_ack, 1'b0);
  endtask

  initial forever begin @(posedge clk); model_step(); end
  initial forever begin @(negedge clk); compare_step(); end

  int          we_n = 0, nz_n = 0;
  logic [31:0] we_addr = '0;
  always @(negedge clk) if (mem_we) begin we_n <= we_n + 1; we_addr <= mem_addr; end
  always @(negedge clk) if (mem_addr != 0) nz_n <= nz_n + 1;

  task automatic do_req(input bit dp, input bit we, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er);
    bit got = 0;
    lat = 0; rd = '0; er = 1'b0;
    if (dp) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
    else    begin i_req = 1; i_addr = a; end
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      lat++;
      if (dp ? d_ack : i_ack) begin
        got = 1; rd = dp ? d_rdata : i_rdata; er = dp ? d_err : i_err;
        break;
      end
    end
    chk("ack_seen", got, 1'b1);
    i_req = 0; d_req = 0; d_we = 0;
  endtask

  initial begin
    int          lat, base_we, base_nz, t0, t1, ovl;
    logic [31:0] rd;
    logic        er;
    byte         glog[$];
    string       es = "DDDDIDDDDI";
    bit          got;

    rst_n = 0; i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    r_rst_n = 0; r_i_req = 0; r_d_req = 0; r_d_we = 0; r_i_addr = '0; r_d_addr = '0; r_d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst3_busy", r_busy, 1'b0);
    rst_n = 1; r_rst_n = 1;
    @(negedge clk);

    // Aligned fetch
    do_req(0, 0, 32'h8, 32'h0, lat, rd, er);
    chk("fetch_lat", lat, 3);
    chk("fetch_rdata", rd, 32'h2005_0005);
    chk("fetch_err", er, 1'b0);

    // Store then load back
    base_we = we_n;
    do_req(1, 1, 32'h4, 32'hDEAD_BEEF, lat, rd, er);
    @(negedge clk);
    chk("store_we_cycles", we_n - base_we, 1);
    chk("store_we_addr", we_addr, 32'h4);
    do_req(1, 0, 32'h4, 32'h0, lat, rd, er);
    chk("load_rdata", rd, 32'hDEAD_BEEF);
    chk("load_lat", lat, W + 2);

    // Unaligned load
    @(negedge clk);
    base_we = we_n; base_nz = nz_n;
    do_req(1, 0, 32'h6, 32'h0, lat, rd, er);
    chk("unal_lat", lat, 1);
    chk("unal_err", er, 1'b1);
    chk("unal_rdata", rd, 32'h0);
    @(negedge clk);
    chk("unal_we", we_n - base_we, 0);
    chk("unal_addr", nz_n - base_nz, 0);

    // Both requesters held: starvation limit forces every fifth grant to fetch
    i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h4;
    t0 = 0; t1 = 0; ovl = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i_ack && d_ack) ovl++;
      if (i_ack) glog.push_back(8'h49);
      if (d_ack) glog.push_back(8'h44);
      if ((i_ack || d_ack) && glog.size() == 1) t0 = k;
      if ((i_ack || d_ack) && glog.size() == 2) t1 = k;
      if (glog.size() == 10) break;
    end
    i_req = 0; d_req = 0;
    chk("seq_len", glog.size(), 10);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk($sformatf("seq%0d", k), glog[k], es[k]);
    chk("throughput", t1 - t0, W + 3);
    chk("overlap", ovl, 0);

    // Reset during second ACCESS cycle of a WAIT_STATES=3 store
    r_d_req = 1; r_d_we = 1; r_d_addr = 32'h10; r_d_wdata = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    chk("r_access_addr", r_mem_addr, 32'h10);
    r_rst_n = 0;
    #1;
    chk("r_busy0", r_busy, 1'b0);
    chk("r_addr0", r_mem_addr, 32'h0);
    chk("r_wdata0", r_mem_wdata, 32'h0);
    chk("r_we0", r_mem_we, 1'b0);
    chk("r_acks0", {r_i_ack, r_d_ack, r_i_err, r_d_err}, 4'h0);
    chk("r_rdata0", r_i_rdata | r_d_rdata, 32'h0);
    r_d_req = 0; r_d_we = 0;
    @(negedge clk);
    r_rst_n = 1;
    @(negedge clk);
    chk("r_we_edges", r_we_edges, 0);
    chk("r_mem_untouched", r_mem[4], 32'h0);
    r_i_req = 1; r_i_addr = 32'h8;
    lat = 0; got = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      lat++;
      if (r_i_ack) begin got = 1; break; end
    end
    chk("r_fetch_seen", got, 1'b1);
    chk("r_fetch_lat", lat, 5);
    chk("r_fetch_rdata", r_i_rdata, 32'h2005_0005);
    chk("r_fetch_err", r_i_err, 1'b0);
    r_i_req = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter for the MIPS subset. It shares one word-addressed memory port between the instruction-fetch requester and the data (load/store) requester. It inserts a programmable number of wait states, rejects unaligned accesses, and returns read data with a one-cycle acknowledge pulse. It sits between the fetch/memory-stage logic and the combined instruction/data memory. That memory is combinational on reads and synchronous on writes.

## Interface
Parameters:
- WAIT_STATES, default 1: extra access cycles per transfer. Legal range 0..15.
- MAX_DATA_GRANTS, default 4: maximum consecutive data grants while i_req is pending, before fetch is forced. Legal range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held with i_addr until i_ack.
- i_addr  in  32  fetch byte address.
- i_rdata  out  32  fetched word; valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse for fetch.
- i_err  out  1  unaligned-fetch flag; valid with i_ack.
- d_req  in  1  data request; held with d_addr, d_we and d_wdata until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse for data.
- d_err  out  1  unaligned-data flag; valid with d_ack.
- mem_addr  out  32  memory address; 0 when idle.
- mem_wdata  out  32  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  32  memory read data (combinational from mem_addr).
- busy  out  1  high in ACCESS and DONE.

## Operation
FSM states: IDLE, ACCESS, DONE.

IDLE:
- Arbitrate on any request and pick a winner.
- Latch the winner's address, we and wdata.
- If the address is aligned: load cnt=WAIT_STATES and go to ACCESS.
- If addr[1:0]≠0: go straight to DONE with err=1 and rdata=0. No memory cycle occurs and mem_we is never asserted.

ACCESS:
- Drive mem_addr and mem_wdata from the latched values.
- While cnt≠0, decrement cnt each cycle.
- When cnt=0:
  - mem_we=latched we, asserted for this single cycle only.
  - Capture mem_rdata into the winner's rdata register.
  - Go to DONE.

DONE:
- The winner's ack is 1 for exactly this cycle.
- Go to IDLE unconditionally. Requests are not sampled in DONE.

Priority:
- d_req beats i_req.
- starve_cnt increments on each data grant made while i_req=1.
- When starve_cnt=MAX_DATA_GRANTS and i_req=1, grant fetch even if d_req=1.
- starve_cnt clears on any fetch grant, and on any arbitration where i_req=0.
- Saturating, 4 bits.

Dropped request: if a requester drops req mid-access, the access still completes and ack still pulses. The requester ignores it.

rdata registers hold their value until the next completion for the same port.

## Timing
- Reset (asynchronous, immediate): state=IDLE, cnt=0, starve_cnt=0. All outputs are 0, including rdata and mem_addr.
- Reset mid-ACCESS aborts the transfer. A store is not performed unless its mem_we edge has already occurred.
- Request sampled at grant edge G. mem_we/capture cycle follows edge G+WAIT_STATES. ack is high in the cycle after edge G+WAIT_STATES+1.
- Aligned request-to-ack latency is WAIT_STATES+2 cycles. Unaligned latency is 1 cycle.
- Back-to-back requests on held req lines: one IDLE cycle between transfers. Throughput is one transfer per WAIT_STATES+3 cycles.
- Simultaneous i_req and d_req in IDLE: data wins, unless the starvation limit is reached.
- i_ack and d_ack are never high in the same cycle.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, DONE)
  - grant encoding (GNT_I, GNT_D)
  - ALIGN_MASK = 2'b11
  - counter width constant (4)
- One sub-module, mem_arb_starve_ctr: the saturating starvation counter plus the force-fetch compare.
- The top level holds the FSM, latches and wait counter.

## Test plan
- WAIT_STATES=1. i_req with i_addr=0x0000_0008; memory model returns 0x2005_0005.
  - i_ack pulses 3 cycles after i_req rises, with i_rdata=0x2005_0005 and i_err=0.
- d_req store, d_addr=0x0000_0004, d_wdata=0xDEAD_BEEF.
  - mem_we is high for exactly one cycle with mem_addr=0x4.
  - A following load at 0x4 returns 0xDEAD_BEEF on d_rdata.
- i_req and d_req held continuously, MAX_DATA_GRANTS=4.
  - Grant sequence is D,D,D,D,I,D,D,D,D,I.
  - Acks never overlap.
- d_req load at d_addr=0x0000_0006.
  - d_ack and d_err are high one cycle later, d_rdata=0, mem_we stays 0, mem_addr stays 0.
- WAIT_STATES=3. Store in progress; reset_n pulsed low during the second ACCESS cycle.
  - No mem_we edge occurs.
  - All outputs are 0 immediately.
  - After release, a fetch completes normally.
